// File: rtl/fwd_engine_seq.sv
// fwd_engine_seq: control and sequencing engine for the residual network
// forward pass.
//
// Streams NUM_UNKNOWNS input beats into the nonlinear layer, then injects a
// float 1.0 bias beat. After waiting NL_LAT cycles it steps the linear layer
// through NUM_NONLIN+1 weights for each equation. It then waits L2_LAT cycles
// and presents one residual per equation on a valid/ready output.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset
//   START, ABORT        begin pass (IDLE only) / synchronous return to IDLE
//   X_VALID/X_READY     input beat handshake, X_DATA beat payload
//   L1_DATA/ADDR/ACC_EN nonlinear layer operand, weight pointer, strobe
//   L2_ADDR/ACC_EN      linear layer weight pointer, strobe
//   ACC_CLR             clear layer accumulators
//   L2_RESULT           linear layer net output
//   RES_VALID/READY     residual handshake, RES_DATA/RES_INDEX payload
//   ERR_ACC_EN          squared-error accumulate strobe (accepted residual)
//   BUSY, DONE          not-idle flag, one-cycle pass-complete pulse
//   ITER_COUNT          completed-pass counter (only with FWD_ITER_CNT_EN)
//
// Optional feature macro: FWD_ITER_CNT_EN
module fwd_engine_seq #(
  parameter int NUM_UNKNOWNS = 2,
  parameter int NUM_NONLIN   = 1,
  parameter int NUM_EQNS     = 2,
  parameter int BIT_WIDTH    = 32,
  parameter int EXTRA_BITS   = 2,
  parameter int NL_LAT       = 3,
  parameter int L2_LAT       = 2,
  parameter int ADDR_W       = 8
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic                            X_VALID,
  output logic                            X_READY,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] X_DATA,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] L1_DATA,
  output logic [ADDR_W-1:0]               L1_ADDR,
  output logic                            L1_ACC_EN,
  output logic [ADDR_W-1:0]               L2_ADDR,
  output logic                            L2_ACC_EN,
  output logic                            ACC_CLR,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] L2_RESULT,
  output logic                            RES_VALID,
  input  logic                            RES_READY,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] RES_DATA,
  output logic [ADDR_W-1:0]               RES_INDEX,
  output logic                            ERR_ACC_EN,
  output logic                            BUSY,
  output logic                            DONE
`ifdef FWD_ITER_CNT_EN
  ,
  output logic [15:0]                     ITER_COUNT
`endif
);

  localparam int DW       = BIT_WIDTH + EXTRA_BITS;
  localparam int WAIT_MAX = (NL_LAT > L2_LAT) ? NL_LAT : L2_LAT;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  // Float 1.0; with flopoco exception bits the leading 2'b01 marks "normal".
  localparam logic [DW-1:0] ONE_F = (EXTRA_BITS == 2) ?
                                    DW'({2'b01, 32'h3F80_0000}) :
                                    DW'(32'h3F80_0000);
  localparam logic [DW-1:0] SIGN_MASK = DW'(1) << (BIT_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BIAS, S_NL_WAIT, S_L2_RUN, S_L2_WAIT, S_OUT, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] h_cnt;
  logic [ADDR_W-1:0] eqn_cnt;
  logic [ADDR_W-1:0] l2_base;   // eqn_cnt*(NUM_NONLIN+1), kept incrementally
  logic [WW-1:0]     wait_cnt;
  logic [DW-1:0]     res_data_q;
  logic [ADDR_W-1:0] res_index_q;

  logic x_fire, res_fire;
  logic last_beat, nl_done, l2_done, h_last, eqn_last;

  // ABORT outranks every handshake in the same cycle.
  assign x_fire    = (state_q == S_LOAD) && X_VALID && !ABORT;
  assign res_fire  = (state_q == S_OUT) && RES_READY && !ABORT;
  assign last_beat = (beat_cnt == ADDR_W'(NUM_UNKNOWNS - 1));
  assign nl_done   = (wait_cnt == WW'(NL_LAT - 1));
  assign l2_done   = (wait_cnt == WW'(L2_LAT - 1));
  assign h_last    = (h_cnt == ADDR_W'(NUM_NONLIN));
  assign eqn_last  = (eqn_cnt == ADDR_W'(NUM_EQNS - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (START) state_d = S_LOAD;
      S_LOAD:    if (x_fire && last_beat) state_d = S_BIAS;
      S_BIAS:    state_d = S_NL_WAIT;
      S_NL_WAIT: if (nl_done) state_d = S_L2_RUN;
      S_L2_RUN:  if (h_last) state_d = S_L2_WAIT;
      S_L2_WAIT: if (l2_done) state_d = S_OUT;
      S_OUT:     if (res_fire) state_d = eqn_last ? S_FIN : S_L2_RUN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (ABORT) state_d = S_IDLE;
  end

  always_comb begin
    X_READY    = 1'b0;
    L1_DATA    = '0;
    L1_ADDR    = '0;
    L1_ACC_EN  = 1'b0;
    L2_ADDR    = '0;
    L2_ACC_EN  = 1'b0;
    ACC_CLR    = 1'b0;
    RES_VALID  = 1'b0;
    ERR_ACC_EN = 1'b0;
    DONE       = 1'b0;
    BUSY       = (state_q != S_IDLE);
    unique case (state_q)
      // RESET gating keeps this Mealy strobe quiet while held in reset.
      S_IDLE: ACC_CLR = START && !ABORT && RESET;
      S_LOAD: begin
        X_READY   = !ABORT;
        L1_ADDR   = beat_cnt;
        L1_ACC_EN = x_fire;
        if (x_fire) L1_DATA = X_DATA;
      end
      S_BIAS: begin
        L1_DATA   = ONE_F;
        L1_ADDR   = ADDR_W'(NUM_UNKNOWNS);
        L1_ACC_EN = !ABORT;
      end
      S_L2_RUN: begin
        L2_ADDR   = l2_base + h_cnt;
        L2_ACC_EN = !ABORT;
      end
      S_OUT: begin
        RES_VALID  = 1'b1;
        ERR_ACC_EN = res_fire;
        ACC_CLR    = res_fire;
      end
      S_FIN: DONE = !ABORT;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      beat_cnt    <= '0;
      h_cnt       <= '0;
      eqn_cnt     <= '0;
      l2_base     <= '0;
      wait_cnt    <= '0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else if (ABORT) begin
      beat_cnt    <= '0;
      h_cnt       <= '0;
      eqn_cnt     <= '0;
      l2_base     <= '0;
      wait_cnt    <= '0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      if (state_q == S_IDLE) beat_cnt <= '0;
      else if (x_fire && !last_beat) beat_cnt <= beat_cnt + 1'b1;

      if (state_q == S_L2_RUN) h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      else                     h_cnt <= '0;

      // One counter serves both latency waits; it is idle-zero elsewhere.
      if (state_q == S_NL_WAIT)      wait_cnt <= nl_done ? '0 : wait_cnt + 1'b1;
      else if (state_q == S_L2_WAIT) wait_cnt <= l2_done ? '0 : wait_cnt + 1'b1;
      else                           wait_cnt <= '0;

      if (state_q == S_IDLE) begin
        eqn_cnt <= '0;
        l2_base <= '0;
      end else if (res_fire && !eqn_last) begin
        eqn_cnt <= eqn_cnt + 1'b1;
        l2_base <= l2_base + ADDR_W'(NUM_NONLIN + 1);
      end

      if (state_q == S_L2_WAIT && l2_done) begin
        res_data_q  <= L2_RESULT ^ SIGN_MASK;
        res_index_q <= eqn_cnt;
      end
    end
  end

  assign RES_DATA  = res_data_q;
  assign RES_INDEX = res_index_q;

`ifdef FWD_ITER_CNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                        ITER_COUNT <= '0;
    else if (DONE && ITER_COUNT != '1) ITER_COUNT <= ITER_COUNT + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_engine_seq.sv
// Testbench for fwd_engine_seq (default parameters). Stimulus pushes the
// expected strobe/residual/done events with their cycle offsets into queues;
// a negedge monitor pops and compares whenever the DUT raises an event.
module tb_fwd_engine_seq;
  localparam int AW = 8;
  localparam int DW = 34;

  logic          CLK, RESET, START, ABORT, X_VALID, X_READY;
  logic [DW-1:0] X_DATA, L1_DATA, L2_RESULT, RES_DATA;
  logic [AW-1:0] L1_ADDR, L2_ADDR, RES_INDEX;
  logic          L1_ACC_EN, L2_ACC_EN, ACC_CLR, RES_VALID, RES_READY;
  logic          ERR_ACC_EN, BUSY, DONE;
`ifdef FWD_ITER_CNT_EN
  logic [15:0]   ITER_COUNT;
`endif

  fwd_engine_seq #(
    .NUM_UNKNOWNS(2), .NUM_NONLIN(1), .NUM_EQNS(2), .BIT_WIDTH(32),
    .EXTRA_BITS(2), .NL_LAT(3), .L2_LAT(2), .ADDR_W(AW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .X_VALID(X_VALID), .X_READY(X_READY), .X_DATA(X_DATA),
    .L1_DATA(L1_DATA), .L1_ADDR(L1_ADDR), .L1_ACC_EN(L1_ACC_EN),
    .L2_ADDR(L2_ADDR), .L2_ACC_EN(L2_ACC_EN), .ACC_CLR(ACC_CLR),
    .L2_RESULT(L2_RESULT), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_INDEX(RES_INDEX), .ERR_ACC_EN(ERR_ACC_EN),
    .BUSY(BUSY), .DONE(DONE)
`ifdef FWD_ITER_CNT_EN
    , .ITER_COUNT(ITER_COUNT)
`endif
  );

  typedef struct {
    int            rel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t q_l1[$];
  ev_t q_l2[$];
  ev_t q_res[$];
  int  q_clr[$];
  int  q_done[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  localparam logic [DW-1:0] ONE_F = 34'h1_3F80_0000;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Monitor: compares every DUT event against the head of its queue.
  ev_t ev;
  int  rel_m;
  int  exp_i;
  always @(negedge CLK) begin
    rel_m = cyc - t0;
    if (L1_ACC_EN) begin
      if (q_l1.size() == 0) chk("l1_unexpected", 1, 0);
      else begin
        ev = q_l1.pop_front();
        chk("l1_cycle", rel_m, ev.rel);
        chk("l1_addr", L1_ADDR, ev.addr);
        chk("l1_data", L1_DATA, ev.data);
      end
    end
    if (L2_ACC_EN) begin
      if (q_l2.size() == 0) chk("l2_unexpected", 1, 0);
      else begin
        ev = q_l2.pop_front();
        chk("l2_cycle", rel_m, ev.rel);
        chk("l2_addr", L2_ADDR, ev.addr);
      end
    end
    if (RES_VALID && RES_READY) begin
      if (q_res.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        ev = q_res.pop_front();
        chk("res_cycle", rel_m, ev.rel);
        chk("res_index", RES_INDEX, ev.addr);
        chk("res_data", RES_DATA, ev.data);
      end
    end
    if (ACC_CLR) begin
      if (q_clr.size() == 0) chk("clr_unexpected", 1, 0);
      else begin
        exp_i = q_clr.pop_front();
        chk("clr_cycle", rel_m, exp_i);
      end
    end
    if (DONE) begin
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        exp_i = q_done.pop_front();
        chk("done_cycle", rel_m, exp_i);
      end
    end
    if (L1_ACC_EN || L2_ACC_EN || ERR_ACC_EN)
      chk("strobe_onehot", $countones({L1_ACC_EN, L2_ACC_EN, ERR_ACC_EN}), 1);
    if (RES_VALID || ERR_ACC_EN)
      chk("err_acc_en", ERR_ACC_EN, RES_VALID && RES_READY);
  end

  task automatic push_ev(inout ev_t q[$], input int rel, input int addr,
                         input logic [DW-1:0] data, input int cut);
    ev_t e;
    e.rel  = rel;
    e.addr = AW'(addr);
    e.data = data;
    if (rel < cut) q.push_back(e);
  endtask

  // One pass: g = idle cycles between beats, r = cycles RES_READY is low in
  // the first OUT, abort_at/reset_at = pass-relative cycle (-1 for none).
  // e0/e1 are the hand-computed residuals for r0/r1.
  task automatic run_pass(input int g, input int r, input int abort_at, input int reset_at,
                          input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                          input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    int cut, done_rel, last;
    cut = 1000;
    if (abort_at >= 0) cut = abort_at;
    if (reset_at >= 0) cut = reset_at;
    done_rel = 17 + g + r;
    last = (cut < 1000) ? cut + 3 : done_rel + 1;
    t0 = cyc;
    q_clr.push_back(0);
    push_ev(q_l1, 1,     0, xa,    cut);
    push_ev(q_l1, 2 + g, 1, xb,    cut);
    push_ev(q_l1, 3 + g, 2, ONE_F, cut);
    push_ev(q_l2, 7 + g, 0, '0, cut);
    push_ev(q_l2, 8 + g, 1, '0, cut);
    push_ev(q_res, 11 + g + r, 0, e0, cut);
    if (11 + g + r < cut) q_clr.push_back(11 + g + r);
    push_ev(q_l2, 12 + g + r, 2, '0, cut);
    push_ev(q_l2, 13 + g + r, 3, '0, cut);
    push_ev(q_res, 16 + g + r, 1, e1, cut);
    if (16 + g + r < cut) q_clr.push_back(16 + g + r);
    if (done_rel < cut) q_done.push_back(done_rel);

    for (int rel = 0; rel <= last; rel++) begin
      START     = (rel == 0) || (reset_at >= 0 && rel >= reset_at && rel < reset_at + 2);
      RESET     = !(reset_at >= 0 && rel >= reset_at && rel < reset_at + 2);
      ABORT     = (rel == abort_at);
      X_VALID   = (rel == 1) || (rel == 2 + g);
      X_DATA    = (rel == 1) ? xa : (rel == 2 + g) ? xb : '0;
      RES_READY = !(rel >= 11 + g && rel < 11 + g + r);
      L2_RESULT = (rel <= 10 + g) ? r0 : r1;
      @(negedge CLK);
      if (r > 0 && rel >= 11 + g && rel < 11 + g + r) begin
        chk("stall_valid", RES_VALID, 1);
        chk("stall_data", RES_DATA, e0);
        chk("stall_index", RES_INDEX, 0);
      end
      if (abort_at >= 0 && rel == abort_at + 1) begin
        chk("abort_busy", BUSY, 0);
        chk("abort_res_valid", RES_VALID, 0);
      end
      if (reset_at >= 0 && rel == reset_at) begin
        chk("reset_outputs", {X_READY, L1_DATA, L1_ADDR, L1_ACC_EN, L2_ADDR, L2_ACC_EN},  0);
        chk("reset_outputs2", {ACC_CLR, RES_VALID, RES_DATA, RES_INDEX, ERR_ACC_EN, BUSY, DONE}, 0);
`ifdef FWD_ITER_CNT_EN
        chk("reset_iter", ITER_COUNT, 0);
`endif
      end
      if (reset_at >= 0 && rel == reset_at + 2) chk("post_reset_busy", BUSY, 0);
      if (cut == 1000 && rel == done_rel + 1) chk("idle_after_done", BUSY, 0);
      @(posedge CLK); #1;
    end
    START = 1'b0; ABORT = 1'b0; X_VALID = 1'b0; RES_READY = 1'b1; RESET = 1'b1;
    chk("left_l1", q_l1.size(), 0);
    chk("left_l2", q_l2.size(), 0);
    chk("left_res", q_res.size(), 0);
    chk("left_clr", q_clr.size(), 0);
    chk("left_done", q_done.size(), 0);
  endtask

  initial begin
    RESET = 1'b0; START = 1'b0; ABORT = 1'b0; X_VALID = 1'b0;
    X_DATA = '0; L2_RESULT = '0; RES_READY = 1'b1;
    @(negedge CLK);
    chk("rst_state", {BUSY, DONE, RES_VALID, X_READY, ACC_CLR, L1_ACC_EN, L2_ACC_EN, ERR_ACC_EN}, 0);
    chk("rst_data", {RES_DATA, RES_INDEX, L1_ADDR, L2_ADDR}, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;

    // +3.0 -> -3.0 ; -2.5 -> +2.5
    run_pass(0, 0, -1, -1, 34'h1_4000_0000, 34'h1_C0A0_0000,
             34'h1_4040_0000, 34'h1_C020_0000, 34'h1_C040_0000, 34'h1_4020_0000);
    // input gap of 4 cycles
    run_pass(4, 0, -1, -1, 34'h1_3F00_0000, 34'h1_4100_0000,
             34'h1_C080_0000, 34'h1_4110_0000, 34'h1_4080_0000, 34'h1_C110_0000);
    // +1.0 result with 5-cycle RES_READY stall
    run_pass(0, 5, -1, -1, 34'h1_4040_0000, 34'h1_4040_0000,
             34'h1_3F80_0000, 34'h0_0000_0000, 34'h1_BF80_0000, 34'h0_8000_0000);
    // abort at cycle 8, then a clean pass
    run_pass(0, 0, 8, -1, 34'h1_4000_0000, 34'h1_4000_0000,
             34'h1_4040_0000, 34'h1_4040_0000, 34'h1_C040_0000, 34'h1_C040_0000);
    run_pass(0, 0, -1, -1, 34'h1_3E80_0000, 34'h1_BE80_0000,
             34'h1_BF00_0000, 34'h1_3F00_0000, 34'h1_3F00_0000, 34'h1_BF00_0000);
`ifdef FWD_ITER_CNT_EN
    chk("iter_count", ITER_COUNT, 4);
`endif

    // ABORT together with START in IDLE stays idle
    START = 1'b1; ABORT = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    chk("abort_start_clr", ACC_CLR, 0);
    @(posedge CLK); #1;
    START = 1'b0; ABORT = 1'b0;
    @(negedge CLK);
    chk("abort_start_busy", BUSY, 0);
    @(posedge CLK); #1;

    // reset mid-pass at cycle 10, then a clean pass
    run_pass(0, 0, -1, 10, 34'h1_4000_0000, 34'h1_4000_0000,
             34'h1_4040_0000, 34'h1_4040_0000, 34'h1_C040_0000, 34'h1_C040_0000);
    run_pass(0, 0, -1, -1, 34'h1_4000_0000, 34'h1_C0A0_0000,
             34'h1_4040_0000, 34'h1_C020_0000, 34'h1_C040_0000, 34'h1_4020_0000);
`ifdef FWD_ITER_CNT_EN
    chk("iter_after_reset", ITER_COUNT, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_engine_seq.md
Name: fwd_engine_seq

Overview:
- Parametrised control-and-sequencing forward engine for the residual network.
- Streams the unknown vector in through a valid/ready handshake and injects the bias beat.
- Drives weight-column address pointers and accumulate/clear strobes for the nonlinear layer, then sequences the linear layer once per equation, waiting out configurable pipeline latencies.
- Emits one residual per equation over a valid/ready output and pulses the squared-error accumulator enable on each accepted residual.

Parameters:
- NUM_UNKNOWNS, 2, input beats per pass (excluding bias)
- NUM_NONLIN, 1, hidden neurons per equation (excluding bias)
- NUM_EQNS, 2, equations/residuals per pass
- BIT_WIDTH, 32, float width
- EXTRA_BITS, 2, flopoco exception bits, 0 or 2
- NL_LAT, 3, cycles from last nonlinear accumulate to valid hidden output, >=1
- L2_LAT, 2, cycles from last linear accumulate to valid L2_RESULT, >=1
- ADDR_W, 8, pointer width; requires NUM_EQNS*(NUM_NONLIN+1) <= 2^ADDR_W

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  begin pass; sampled only in IDLE
- ABORT  in  1  synchronous return to IDLE from any state
- X_VALID  in  1  input beat valid
- X_READY  out  1  engine accepts input beat
- X_DATA  in  BIT_WIDTH+EXTRA_BITS  unknown value
- L1_DATA  out  BIT_WIDTH+EXTRA_BITS  operand to nonlinear layer
- L1_ADDR  out  ADDR_W  nonlinear weight pointer
- L1_ACC_EN  out  1  nonlinear accumulate strobe
- L2_ADDR  out  ADDR_W  linear weight pointer
- L2_ACC_EN  out  1  linear accumulate strobe
- ACC_CLR  out  1  clear all layer accumulators
- L2_RESULT  in  BIT_WIDTH+EXTRA_BITS  linear layer net output
- RES_VALID  out  1  residual valid
- RES_READY  in  1  downstream accepts residual
- RES_DATA  out  BIT_WIDTH+EXTRA_BITS  residual = L2_RESULT with sign bit inverted
- RES_INDEX  out  ADDR_W  equation index of RES_DATA
- ERR_ACC_EN  out  1  squared-error accumulate strobe
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pass-complete pulse

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- FSM states: IDLE, LOAD, BIAS, NL_WAIT, L2_RUN, L2_WAIT, OUT, FIN.
- IDLE:
  - START=1 -> ACC_CLR=1 that cycle (Mealy); next state LOAD.
  - START is ignored in all other states.
- LOAD:
  - X_READY=1.
  - Each X_VALID&X_READY beat: L1_DATA=X_DATA, L1_ACC_EN=1, L1_ADDR=beat index 0..NUM_UNKNOWNS-1.
  - No beat -> strobes stay 0; pointer holds.
  - After beat NUM_UNKNOWNS-1 -> BIAS.
- BIAS: one cycle.
  - L1_DATA=float 1.0: 34'h1_3F80_0000 for EXTRA_BITS=2; 32'h3F80_0000 for EXTRA_BITS=0.
  - L1_ACC_EN=1, L1_ADDR=NUM_UNKNOWNS.
  - Next -> NL_WAIT.
- NL_WAIT: exactly NL_LAT cycles, then L2_RUN.
- L2_RUN: NUM_NONLIN+1 consecutive cycles for current equation e.
  - L2_ACC_EN=1 each cycle.
  - L2_ADDR=e*(NUM_NONLIN+1)+h, h=0..NUM_NONLIN.
  - Next -> L2_WAIT.
- L2_WAIT: exactly L2_LAT cycles.
  - Final cycle captures RES_DATA from L2_RESULT (sign bit BIT_WIDTH-1 inverted) and sets RES_INDEX=e.
  - Next -> OUT.
- OUT:
  - RES_VALID=1; RES_DATA/RES_INDEX held stable until handshake.
  - On RES_VALID&RES_READY, same cycle: ERR_ACC_EN=1, ACC_CLR=1 (clears linear accumulator).
  - After handshake: e<NUM_EQNS-1 -> e++, L2_RUN; else -> FIN.
  - RES_VALID is not combinationally dependent on RES_READY.
- FIN: DONE=1 for one cycle, then IDLE; hidden values retained until next START.
- ABORT:
  - Any state -> IDLE next cycle; counters cleared; RES_VALID drops; no DONE.
  - ABORT has priority over all handshakes in the same cycle.
  - ABORT and START both high in IDLE -> stay IDLE.
- RESET asserted mid-pass: immediate IDLE, all outputs 0, no DONE.
- Strobes L1_ACC_EN, L2_ACC_EN and ERR_ACC_EN are never high simultaneously.

Optional Feature:
- Macro FWD_ITER_CNT_EN.
- Defined: adds output ITER_COUNT (16 bits).
  - Resets to 0; increments on each DONE; saturates at 16'hFFFF.
  - ABORT does not increment it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults, X_VALID=1 and RES_READY=1 constantly, START at cycle 0 -> ACC_CLR cycle 0; L1_ADDR 0,1,2 at cycles 1-3; L2_ADDR 0,1 at 7-8 and 2,3 at 12-13; RES_VALID at 11 and 16; DONE at cycle 17.
- LOAD with X_VALID=0 for 4 cycles between the two beats -> L1_ACC_EN low during the gap; DONE delayed to cycle 21; L1_ADDR sequence unchanged.
- L2_RESULT=34'h1_3F80_0000 (+1.0) with RES_READY low 5 cycles in OUT -> RES_DATA=34'h1_BF80_0000 stable, RES_INDEX=0, ERR_ACC_EN only on the accepting cycle.
- ABORT at cycle 8 of a pass -> IDLE at cycle 9, BUSY=0, no DONE; new START completes a normal 17-cycle pass.
- RESET low at cycle 10 -> all outputs 0 immediately; START ignored while RESET low.
- FWD_ITER_CNT_EN defined, 3 full passes plus 1 aborted pass -> ITER_COUNT=3.
